pic16_seq_stack: RTL and testbench
==================================

// Module: pic16_seq_stack
// PURPOSE
//  Parametrised program sequencer for the PIC16-class core: program counter plus hardware return stack.
//  Adds configurable stack depth, circular or saturating overflow policy, sticky over/underflow flags,
//  interrupt entry to a vector, and an optional stack-overflow trap.
//  Sits between the decode/control logic (load/push/pop strobes) and instruction memory (PC -> IMEM address).
// PARAMETERS
//  AW        13      PC width in bits (>= 9)
//  LW        11      literal jump field width (GOTO/CALL operand), LW < AW
//  DEPTH     8       return stack entries, power of 2, >= 2
//  WRAP      1       1 = circular stack (overflow overwrites oldest), 0 = saturating (overflow push dropped)
//  INT_VEC   13'h004 interrupt entry address
//  TRAP_VEC  13'h008 stack-overflow trap address (used only with STACK_OVF_TRAP_EN)
// PORTS
//  CLK       in   1         clock, all state updates on rising edge
//  RST       in   1         synchronous reset, active high
//  STALL     in   1         hold PC (SLEEP); lowest priority, below all loads
//  JMP       in   1         GOTO/CALL load strobe
//  JA        in   LW        jump literal (IR[LW-1:0])
//  PCLATH    in   AW-8      PC high latch
//  PCL_W     in   1         computed jump: write to PCL
//  PCL_D     in   8         PCL write data
//  PUSH      in   1         push return address (CALL = JMP+PUSH)
//  POP       in   1         pop return address into PC (RETURN/RETLW/RETFIE)
//  INT_REQ   in   1         interrupt request, level
//  FLG_CLR   in   1         clear sticky STK_OVF/STK_UNF
//  PC        out  AW        program counter (IMEM address)
//  STKN      out  log2(DEPTH)+1  valid entries, 0..DEPTH
//  STK_FULL  out  1         STKN == DEPTH
//  STK_EMPTY out  1         STKN == 0
//  STK_OVF   out  1         sticky: push attempted with STK_FULL
//  STK_UNF   out  1         sticky: pop attempted with STK_EMPTY
//  INT_ACK   out  1         one-cycle pulse on interrupt entry
//  TRAP      out  1         one-cycle pulse on overflow trap (0 when feature compiled out)
// BEHAVIOUR
//  Reset (sync): PC=0, STKN=0, pointer=0, STK_OVF=STK_UNF=INT_ACK=TRAP=0; stack contents undefined.
//  PC update priority per cycle: RST > INT > JMP > PCL_W > POP > STALL > PC+1 (wraps at 2^AW).
//   INT: INT_REQ && !JMP && !POP && !PCL_W -> push PC, PC<=INT_VEC, INT_ACK=1 next cycle; level
//        re-entry is controller's responsibility (deassert INT_REQ after INT_ACK).
//   JMP: PC <= {PCLATH[AW-9 -: AW-LW], JA}  (top AW-LW bits of PCLATH above JA).
//   PCL_W: PC <= {PCLATH, PCL_D}.  POP: PC <= top entry.
//  Push value = current PC (already points to next instruction); push and JMP same cycle = CALL.
//  Push with !STK_FULL: write entry, pointer+1, STKN+1.
//  Push with STK_FULL: STK_OVF<=1; WRAP=1 -> write and pointer+1 mod DEPTH, STKN stays DEPTH;
//   WRAP=0 -> push dropped, pointer/STKN unchanged. Target load (JMP/INT) still happens.
//  Pop with !STK_EMPTY: PC<=entry[pointer-1], pointer-1, STKN-1.
//  Pop with STK_EMPTY: STK_UNF<=1; WRAP=1 -> PC<=entry[pointer-1], pointer-1 mod DEPTH, STKN stays 0;
//   WRAP=0 -> PC<=0, pointer unchanged.
//  PUSH and POP same cycle: illegal from decode; defined as POP only, push ignored.
//  FLG_CLR clears sticky flags; a new event in the same cycle wins (flag set).
//  Load latency: every update visible on PC one cycle after strobe; no combinational path strobe->PC.
//  RST mid-sequence discards any push/pop in that cycle.
// CONFIGURATION
//  STACK_OVF_TRAP_EN defined: overflow push (any WRAP) overrides target: PC<=TRAP_VEC, TRAP=1 one cycle;
//   push handled per WRAP as above. Undefined: no trap, TRAP tied 0, PC follows normal priority.
// TESTING
//  RST 1 cycle, release -> PC 0,1,2,..; STKN=0, STK_EMPTY=1, all flags 0.
//  PC=0x0123, PCLATH=5'h18, JMP+PUSH JA=0x055 -> PC=0x1855, STKN=1; POP -> PC=0x0123, STKN=0.
//  WRAP=1: 9 pushes -> STKN=8, STK_OVF=1; 8 pops return last 8 addresses, oldest lost; 9th pop STK_UNF=1.
//  WRAP=0: 9th push dropped, STK_OVF=1; 8 pops return first 8 addresses; 9th pop -> PC=0, STK_UNF=1.
//  INT_REQ at PC=0x0040 -> PC=0x004, INT_ACK pulse, top=0x0040; INT_REQ with JMP same cycle -> JMP wins.
//  STACK_OVF_TRAP_EN: 9th CALL -> PC=0x008, TRAP pulse; STALL=1 holds PC; FLG_CLR clears flags.

Source files
------------

// File: rtl/pic16_seq_stack.sv
// pic16_seq_stack: program counter and hardware return stack for a PIC16-class core.
// The PC advances by one each cycle unless a load is requested. Load sources are
// interrupt entry, GOTO/CALL literal, computed PCL write, return pop, and SLEEP hold.
// The return stack has a configurable depth and either a circular or a saturating
// overflow policy. Overflow and underflow are reported through sticky flags.
// Optional feature: define STACK_OVF_TRAP_EN to redirect an overflowing push to
// TRAP_VEC and pulse TRAP. When the macro is undefined, TRAP is constant 0.
module pic16_seq_stack #(
  parameter int unsigned   AW       = 13,
  parameter int unsigned   LW       = 11,
  parameter int unsigned   DEPTH    = 8,
  parameter int unsigned   WRAP     = 1,
  parameter logic [AW-1:0] INT_VEC  = 13'h004,
  parameter logic [AW-1:0] TRAP_VEC = 13'h008
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       STALL,
  input  logic                       JMP,
  input  logic [LW-1:0]              JA,
  input  logic [AW-9:0]              PCLATH,
  input  logic                       PCL_W,
  input  logic [7:0]                 PCL_D,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic                       INT_REQ,
  input  logic                       FLG_CLR,
  output logic [AW-1:0]              PC,
  output logic [$clog2(DEPTH):0]     STKN,
  output logic                       STK_FULL,
  output logic                       STK_EMPTY,
  output logic                       STK_OVF,
  output logic                       STK_UNF,
  output logic                       INT_ACK,
  output logic                       TRAP
);

  localparam int unsigned PW     = $clog2(DEPTH);
  localparam logic [PW:0] N_FULL = (PW+1)'(DEPTH);
  localparam bit          CIRC   = (WRAP != 0);

  typedef enum logic [2:0] {
    SRC_INC,
    SRC_HOLD,
    SRC_POP,
    SRC_PCL,
    SRC_JMP,
    SRC_INT,
    SRC_TRAP
  } pc_src_e;

  logic [AW-1:0] r_stack [DEPTH];
  logic [AW-1:0] r_pc;
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_stkn;
  logic          r_ovf;
  logic          r_unf;
  logic          r_int_ack;
  logic          r_trap;

  logic          w_full;
  logic          w_empty;
  logic          w_int;
  logic          w_push;
  logic          w_ovf_push;
  logic          w_unf_pop;
  logic          w_wr;
  logic          w_trap;
  logic [PW-1:0] w_ptr_inc;
  logic [PW-1:0] w_ptr_dec;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW:0]   w_stkn_nxt;
  logic [AW-1:0] w_pop_val;
  logic [AW-1:0] w_jmp_tgt;
  logic [AW-1:0] w_pcl_tgt;
  logic [AW-1:0] w_pc_nxt;
  pc_src_e       w_src;

  assign w_full     = (r_stkn == N_FULL);
  assign w_empty    = (r_stkn == '0);
  // Interrupt entry only in a cycle without any other PC load.
  assign w_int      = INT_REQ && !JMP && !POP && !PCL_W;
  // A pop in the same cycle suppresses any push, including the one that interrupt entry implies.
  assign w_push     = (PUSH || w_int) && !POP;
  assign w_ovf_push = w_push && w_full;
  assign w_unf_pop  = POP && w_empty;
  assign w_wr       = w_push && (!w_full || CIRC);
  assign w_ptr_inc  = r_ptr + PW'(1);
  assign w_ptr_dec  = r_ptr - PW'(1);
  // A saturating stack returns address 0 when it is popped while empty.
  assign w_pop_val  = (w_empty && !CIRC) ? '0 : r_stack[w_ptr_dec];
  assign w_jmp_tgt  = {PCLATH[AW-9 -: AW-LW], JA};
  assign w_pcl_tgt  = {PCLATH, PCL_D};

`ifdef STACK_OVF_TRAP_EN
  assign w_trap = w_ovf_push;
`else
  assign w_trap = 1'b0;
`endif

  // Pick the PC source by priority: trap, interrupt, jump, PCL write, pop, stall, increment.
  always_comb begin
    w_src = SRC_INC;
    if (w_trap)        w_src = SRC_TRAP;
    else if (w_int)    w_src = SRC_INT;
    else if (JMP)      w_src = SRC_JMP;
    else if (PCL_W)    w_src = SRC_PCL;
    else if (POP)      w_src = SRC_POP;
    else if (STALL)    w_src = SRC_HOLD;
  end

  // Form the next PC from the selected source.
  always_comb begin
    w_pc_nxt = r_pc + AW'(1);
    case (w_src)
      SRC_TRAP: w_pc_nxt = TRAP_VEC;
      SRC_INT:  w_pc_nxt = INT_VEC;
      SRC_JMP:  w_pc_nxt = w_jmp_tgt;
      SRC_PCL:  w_pc_nxt = w_pcl_tgt;
      SRC_POP:  w_pc_nxt = w_pop_val;
      SRC_HOLD: w_pc_nxt = r_pc;
      default:  w_pc_nxt = r_pc + AW'(1);
    endcase
  end

  // Update the stack pointer and entry count under the chosen overflow policy.
  // When the stack is circular, the pointer still moves on overflow or underflow,
  // but the entry count stays pinned.
  always_comb begin
    w_ptr_nxt  = r_ptr;
    w_stkn_nxt = r_stkn;
    if (POP) begin
      if (!w_empty) begin
        w_ptr_nxt  = w_ptr_dec;
        w_stkn_nxt = r_stkn - (PW+1)'(1);
      end else if (CIRC) begin
        w_ptr_nxt  = w_ptr_dec;
      end
    end else if (w_push) begin
      if (!w_full) begin
        w_ptr_nxt  = w_ptr_inc;
        w_stkn_nxt = r_stkn + (PW+1)'(1);
      end else if (CIRC) begin
        w_ptr_nxt  = w_ptr_inc;
      end
    end
  end

  // Write the stack storage. It has no reset, and a cycle with reset asserted performs no write.
  always_ff @(posedge CLK) begin
    if (!RST && w_wr) begin
      r_stack[r_ptr] <= r_pc;
    end
  end

  // Update the PC, pointer, count, sticky flags and event pulses.
  // In each sticky flag, a new event has priority over FLG_CLR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc      <= '0;
      r_ptr     <= '0;
      r_stkn    <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_int_ack <= 1'b0;
      r_trap    <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_ptr     <= w_ptr_nxt;
      r_stkn    <= w_stkn_nxt;
      r_ovf     <= w_ovf_push ? 1'b1 : (FLG_CLR ? 1'b0 : r_ovf);
      r_unf     <= w_unf_pop  ? 1'b1 : (FLG_CLR ? 1'b0 : r_unf);
      r_int_ack <= w_int;
      r_trap    <= w_trap;
    end
  end

  assign PC        = r_pc;
  assign STKN      = r_stkn;
  assign STK_FULL  = w_full;
  assign STK_EMPTY = w_empty;
  assign STK_OVF   = r_ovf;
  assign STK_UNF   = r_unf;
  assign INT_ACK   = r_int_ack;
  assign TRAP      = r_trap;

endmodule

// File: tb/tb_pic16_seq_stack.sv
// Testbench for pic16_seq_stack. It runs a circular (WRAP=1) and a saturating (WRAP=0)
// instance on the same stimulus. Each stimulus cycle pushes its hand-computed
// expectation into a queue. A monitor pops one entry after each clock edge and checks it
// against both instances.
module tb_pic16_seq_stack;

  logic        CLK = 1'b0;
  logic        RST, STALL, JMP, PCL_W, PUSH, POP, INT_REQ, FLG_CLR;
  logic [10:0] JA;
  logic [4:0]  PCLATH;
  logic [7:0]  PCL_D;

  logic [12:0] pc_a, pc_b;
  logic [3:0]  stkn_a, stkn_b;
  logic        full_a, full_b, empty_a, empty_b, ovf_a, ovf_b, unf_a, unf_b;
  logic        ack_a, ack_b, trap_a, trap_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [12:0] pa;
    logic [12:0] pb;
    int          stkn;
    bit          ovf;
    bit          unf;
    bit          ack;
    bit          trap;
  } exp_t;

  exp_t q[$];

  always #5 CLK = ~CLK;

  pic16_seq_stack #(.AW(13), .LW(11), .DEPTH(8), .WRAP(1),
                    .INT_VEC(13'h004), .TRAP_VEC(13'h008)) u_wrap (
    .CLK(CLK), .RST(RST), .STALL(STALL), .JMP(JMP), .JA(JA), .PCLATH(PCLATH),
    .PCL_W(PCL_W), .PCL_D(PCL_D), .PUSH(PUSH), .POP(POP), .INT_REQ(INT_REQ),
    .FLG_CLR(FLG_CLR), .PC(pc_a), .STKN(stkn_a), .STK_FULL(full_a),
    .STK_EMPTY(empty_a), .STK_OVF(ovf_a), .STK_UNF(unf_a), .INT_ACK(ack_a),
    .TRAP(trap_a));

  pic16_seq_stack #(.AW(13), .LW(11), .DEPTH(8), .WRAP(0),
                    .INT_VEC(13'h004), .TRAP_VEC(13'h008)) u_sat (
    .CLK(CLK), .RST(RST), .STALL(STALL), .JMP(JMP), .JA(JA), .PCLATH(PCLATH),
    .PCL_W(PCL_W), .PCL_D(PCL_D), .PUSH(PUSH), .POP(POP), .INT_REQ(INT_REQ),
    .FLG_CLR(FLG_CLR), .PC(pc_b), .STKN(stkn_b), .STK_FULL(full_b),
    .STK_EMPTY(empty_b), .STK_OVF(ovf_b), .STK_UNF(unf_b), .INT_ACK(ack_b),
    .TRAP(trap_b));

  task automatic chk(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
    end
  endtask

  // Monitor: the state after each edge is compared with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "wrap.pc",    32'(pc_a),    32'(e.pa));
        chk(e.name, "sat.pc",     32'(pc_b),    32'(e.pb));
        chk(e.name, "wrap.stkn",  32'(stkn_a),  32'(e.stkn));
        chk(e.name, "sat.stkn",   32'(stkn_b),  32'(e.stkn));
        chk(e.name, "wrap.full",  32'(full_a),  32'(e.stkn == 8));
        chk(e.name, "sat.full",   32'(full_b),  32'(e.stkn == 8));
        chk(e.name, "wrap.empty", 32'(empty_a), 32'(e.stkn == 0));
        chk(e.name, "sat.empty",  32'(empty_b), 32'(e.stkn == 0));
        chk(e.name, "wrap.ovf",   32'(ovf_a),   32'(e.ovf));
        chk(e.name, "sat.ovf",    32'(ovf_b),   32'(e.ovf));
        chk(e.name, "wrap.unf",   32'(unf_a),   32'(e.unf));
        chk(e.name, "sat.unf",    32'(unf_b),   32'(e.unf));
        chk(e.name, "wrap.ack",   32'(ack_a),   32'(e.ack));
        chk(e.name, "sat.ack",    32'(ack_b),   32'(e.ack));
        chk(e.name, "wrap.trap",  32'(trap_a),  32'(e.trap));
        chk(e.name, "sat.trap",   32'(trap_b),  32'(e.trap));
      end
    end
  end

  task automatic nxt();
    @(negedge CLK);
    RST = 0; STALL = 0; JMP = 0; PCL_W = 0; PUSH = 0; POP = 0; INT_REQ = 0; FLG_CLR = 0;
    JA = '0; PCLATH = '0; PCL_D = '0;
  endtask

  task automatic ex(input string n, input logic [12:0] pa, input logic [12:0] pb,
                    input int stkn, input bit ovf, input bit unf, input bit ack,
                    input bit trap);
    exp_t e;
    e.name = n; e.pa = pa; e.pb = pb; e.stkn = stkn;
    e.ovf = ovf; e.unf = unf; e.ack = ack; e.trap = trap;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1; STALL = 0; JMP = 0; PCL_W = 0; PUSH = 0; POP = 0; INT_REQ = 0; FLG_CLR = 0;
    JA = '0; PCLATH = '0; PCL_D = '0;

    nxt(); RST = 1;
    ex("reset", 13'h000, 13'h000, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      nxt();
      ex($sformatf("inc%0d", i), 13'(i), 13'(i), 0, 0, 0, 0, 0);
    end

    // Walk through a computed jump, then a CALL and its RETURN.
    nxt(); PCL_W = 1; PCLATH = 5'h01; PCL_D = 8'h23;
    ex("pclw", 13'h0123, 13'h0123, 0, 0, 0, 0, 0);
    nxt(); JMP = 1; PUSH = 1; PCLATH = 5'h18; JA = 11'h055;
    ex("call", 13'h1855, 13'h1855, 1, 0, 0, 0, 0);
    nxt(); POP = 1;
    ex("ret", 13'h0123, 13'h0123, 0, 0, 0, 0, 0);
    nxt();
    ex("inc_after_ret", 13'h0124, 13'h0124, 0, 0, 0, 0, 0);
    nxt(); STALL = 1;
    ex("stall_hold", 13'h0124, 13'h0124, 0, 0, 0, 0, 0);
    nxt(); STALL = 1; PCL_W = 1; PCL_D = 8'h40;
    ex("stall_vs_pclw", 13'h0040, 13'h0040, 0, 0, 0, 0, 0);

    // Take an interrupt and return from it, then raise INT_REQ together with a jump, which must win.
    nxt(); INT_REQ = 1;
    ex("int_entry", 13'h0004, 13'h0004, 1, 0, 0, 1, 0);
    nxt();
    ex("int_ack_pulse", 13'h0005, 13'h0005, 1, 0, 0, 0, 0);
    nxt(); POP = 1;
    ex("int_ret", 13'h0040, 13'h0040, 0, 0, 0, 0, 0);
    nxt(); INT_REQ = 1; JMP = 1; JA = 11'h100;
    ex("int_vs_jmp", 13'h0100, 13'h0100, 0, 0, 0, 0, 0);
    nxt();
    ex("no_late_ack", 13'h0101, 13'h0101, 0, 0, 0, 0, 0);

    // Issue nine CALLs. The pushed values are 0x101, 0x200, 0x210, ..., 0x270.
    for (int k = 0; k < 9; k++) begin
      nxt(); JMP = 1; PUSH = 1; JA = 11'h200 + 11'(16 * k);
      if (k < 8)
        ex($sformatf("call%0d", k), 13'h200 + 13'(16 * k), 13'h200 + 13'(16 * k),
           k + 1, 0, 0, 0, 0);
      else
`ifdef STACK_OVF_TRAP_EN
        ex("call8_trap", 13'h0008, 13'h0008, 8, 1, 0, 0, 1);
`else
        ex("call8_ovf", 13'h0280, 13'h0280, 8, 1, 0, 0, 0);
`endif
    end

    // The circular stack returns 0x270 down to 0x200. The saturating stack returns 0x260 down to 0x200, then 0x101.
    for (int j = 0; j < 8; j++) begin
      nxt(); POP = 1;
      ex($sformatf("pop%0d", j), 13'h270 - 13'(16 * j),
         (j == 7) ? 13'h101 : 13'h260 - 13'(16 * j), 7 - j, 1, 0, 0, 0);
    end
    nxt(); POP = 1;
    ex("pop_empty", 13'h0270, 13'h0000, 0, 1, 1, 0, 0);
    nxt(); FLG_CLR = 1;
    ex("flg_clr", 13'h0271, 13'h0001, 0, 0, 0, 0, 0);
    nxt(); FLG_CLR = 1; POP = 1;
    ex("clr_vs_unf", 13'h0260, 13'h0000, 0, 0, 1, 0, 0);

    // Assert reset in the same cycle as a CALL; the push must be discarded. Then check the PC wraps at the top of the address space.
    nxt(); RST = 1; JMP = 1; PUSH = 1; PCLATH = 5'h18; JA = 11'h001;
    ex("rst_mid", 13'h0000, 13'h0000, 0, 0, 0, 0, 0);
    nxt();
    ex("after_rst", 13'h0001, 13'h0001, 0, 0, 0, 0, 0);
    nxt(); PCL_W = 1; PCLATH = 5'h1F; PCL_D = 8'hFF;
    ex("pc_max", 13'h1FFF, 13'h1FFF, 0, 0, 0, 0, 0);
    nxt();
    ex("pc_wrap", 13'h0000, 13'h0000, 0, 0, 0, 0, 0);
    nxt();
    ex("pc_after_wrap", 13'h0001, 13'h0001, 0, 0, 0, 0, 0);

    nxt(); nxt(); nxt();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
